// File: rtl/quad_decoder_if.sv
// Signal bundle between a quadrature encoder front end and the decoder.
// Contract: step is a one-cycle valid strobe with no ready; up_dn is meaningful when step is high and holds between steps.
interface quad_decoder_if;
    logic a_in;
    logic b_in;
    logic err_clr;
    logic step;
    logic up_dn;
    logic err;
    logic locked;
    logic dbg_state;

    modport master (
        output a_in,
        output b_in,
        output err_clr,
        input  step,
        input  up_dn,
        input  err,
        input  locked,
        input  dbg_state
    );

    modport slave (
        input  a_in,
        input  b_in,
        input  err_clr,
        output step,
        output up_dn,
        output err,
        output locked,
        output dbg_state
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters A/B, then emits one step pulse
// per legal Gray-code transition with direction, plus a sticky illegal-transition flag.
module quad_decoder #(
    parameter int FILT_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    quad_decoder_if.slave  bus
);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [3:0] FILT_MAX  = 4'(FILT_LEN - 1);
    localparam logic [4:0] INIT_LAST = 5'(FILT_LEN + 1);

    // Bit 1 is channel A, bit 0 is channel B, so each vector reads as {A,B}.
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    logic [1:0] prev;
    logic [3:0] cnt [2];
    logic [4:0] init_cnt;
    state_t     state;
    logic       step;
    logic       up_dn;
    logic       err;
    logic       locked;

    // Forward Gray sequence 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] up_next(input logic [1:0] ab);
        case (ab)
            2'b00:   up_next = 2'b10;
            2'b10:   up_next = 2'b11;
            2'b11:   up_next = 2'b01;
            default: up_next = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            filt     <= 2'b00;
            prev     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= 4'd0;
            end
            init_cnt <= 5'd0;
            state    <= INIT;
            step     <= 1'b0;
            up_dn    <= 1'b1;
            err      <= 1'b0;
            locked   <= 1'b0;
        end else begin
            sync1 <= {bus.a_in, bus.b_in};
            sync2 <= sync1;
            step  <= 1'b0;
            if (bus.err_clr) begin
                err <= 1'b0;
            end
            case (state)
                INIT: begin
                    // Track the inputs directly so TRACK starts with no pending transition.
                    filt <= sync2;
                    prev <= sync2;
                    for (int i = 0; i < 2; i++) begin
                        cnt[i] <= 4'd0;
                    end
                    if (init_cnt == INIT_LAST) begin
                        state  <= TRACK;
                        locked <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 5'd1;
                    end
                end
                TRACK: begin
                    for (int i = 0; i < 2; i++) begin
                        if (sync2[i] == filt[i]) begin
                            cnt[i] <= 4'd0;
                        end else if (cnt[i] == FILT_MAX) begin
                            filt[i] <= sync2[i];
                            cnt[i]  <= 4'd0;
                        end else begin
                            cnt[i] <= cnt[i] + 4'd1;
                        end
                    end
                    prev <= filt;
                    // Any single-bit change is legal; a double change sets err, which overrides err_clr.
                    if (filt != prev) begin
                        if (filt == up_next(prev)) begin
                            step  <= 1'b1;
                            up_dn <= 1'b1;
                        end else if (prev == up_next(filt)) begin
                            step  <= 1'b1;
                            up_dn <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign bus.step      = step;
    assign bus.up_dn     = up_dn;
    assign bus.err       = err;
    assign bus.locked    = locked;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (FILT_LEN=4): expected step pulses are queued with
// their arrival cycle and direction; a negedge monitor pops and compares them.
module tb_quad_decoder;
    localparam int W = 33;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    logic [W-1:0] exp_q[$];

    quad_decoder_if bus ();

    quad_decoder #(.FILT_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a new raw level at a negedge; if a step is expected it lands 7 posedges later.
    task automatic drive(input logic a, input logic b, input bit exp_step, input logic dir, input int hold);
        bus.a_in = a;
        bus.b_in = b;
        if (exp_step) exp_q.push_back({32'(cyc + 7), dir});
        repeat (hold) @(negedge clk);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (bus.step === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("step_unexpected", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("step_cycle", 32'(cyc), e[W-1:1]);
                check("step_dir", {31'd0, bus.up_dn}, {31'd0, e[0]});
            end
        end
    end

    // Stimulus
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        bus.err_clr = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_step", {31'd0, bus.step}, 32'd0);
        check("reset_up_dn", {31'd0, bus.up_dn}, 32'd1);
        check("reset_err", {31'd0, bus.err}, 32'd0);
        check("reset_locked", {31'd0, bus.locked}, 32'd0);
        check("reset_state", {31'd0, bus.dbg_state}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("lock_timing", {31'd0, bus.locked}, (k == 6) ? 32'd1 : 32'd0);
            check("lock_err", {31'd0, bus.err}, 32'd0);
        end
        check("lock_state", {31'd0, bus.dbg_state}, 32'd1);
        repeat (4) @(negedge clk);

        // Reset in the middle of a filter count: no step, back to INIT
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_locked", {31'd0, bus.locked}, 32'd0);
        check("midrst_state", {31'd0, bus.dbg_state}, 32'd0);
        repeat (5) @(negedge clk);
        check("midrst_still_init", {31'd0, bus.locked}, 32'd0);
        @(negedge clk);
        check("midrst_relock", {31'd0, bus.locked}, 32'd1);
        repeat (4) @(negedge clk);

        // 01 -> 11 is down, then walk up to 00
        drive(1'b1, 1'b1, 1'b1, 1'b0, 10);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10);

        // Forward rotation
        drive(1'b1, 1'b0, 1'b1, 1'b1, 10);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10);
        check("fwd_up_dn", {31'd0, bus.up_dn}, 32'd1);

        // Reverse rotation, then back to 00
        drive(1'b0, 1'b1, 1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 10);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 10);
        check("rev_up_dn", {31'd0, bus.up_dn}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10);

        // Glitches: 3-cycle pulse rejected, 5-cycle pulse gives up then down
        bus.a_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.a_in = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch3_up_dn", {31'd0, bus.up_dn}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 12);
        check("glitch5_up_dn", {31'd0, bus.up_dn}, 32'd0);

        // Illegal 00 -> 11
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3);
        check("illegal_err_early", {31'd0, bus.err}, 32'd0);
        repeat (5) @(negedge clk);
        check("illegal_err_set", {31'd0, bus.err}, 32'd1);
        check("illegal_up_dn_hold", {31'd0, bus.up_dn}, 32'd0);
        repeat (5) @(negedge clk);
        check("illegal_err_sticky", {31'd0, bus.err}, 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("err_clr", {31'd0, bus.err}, 32'd0);

        // Illegal 11 -> 00 detected on the same edge err_clr is sampled: set wins
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("err_set_wins", {31'd0, bus.err}, 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("err_clr_again", {31'd0, bus.err}, 32'd0);

        repeat (20) @(negedge clk);
        check("steps_outstanding", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
